gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a combinational gate under test (GUT), such as a NAND-built and/or/xor gate, by driving every input combination. It waits a programmable settle time per vector, samples the gate output into a truth table, and compares the result against an expected table. It is a synthesizable, self-checking replacement for hand-written delay-based stimulus blocks. It sits between a host or testbench and one GUT instance.

---
 rtl/gate_sweep_pkg.sv | 30 +++
 rtl/gate_sweep_ctrl_settle_timer.sv | 31 +++
 rtl/gate_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types, sizing helpers and reference truth tables for the gate sweep sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned N_IN_DEFAULT   = 2;
    localparam int unsigned N_IN_MAX       = 6;
    localparam int unsigned SETTLE_DEFAULT = 1;

    function automatic int unsigned vec_count(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Counter must hold SETTLE_CYCLES itself, so size for SETTLE_CYCLES+1 states.
    function automatic int unsigned timer_width(input int unsigned settle);
        return (settle < 32'd2) ? 32'd1 : 32'($clog2(settle + 32'd1));
    endfunction

    // Reference tables for two-input gates; bit i is the output for vector i = {a, b}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned CW = timer_width(SETTLE_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(SETTLE_CYCLES);
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // Flags the decrement that brings the count to zero, i.e. the last settle cycle.
    assign zero_c = dec && (count == CW'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational gate under test: drives every
// input vector, samples the gate output into a truth table and grades it.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [vec_count(N_IN)-1:0]  expected,
    output logic [N_IN-1:0]             gut_in,
    input  logic                        gut_out,
    output logic                        busy,
    output logic                        done,
    output logic [vec_count(N_IN)-1:0]  truth_table,
    output logic                        pass,
    output logic [N_IN:0]               mismatch_count
);

    localparam int unsigned VEC = vec_count(N_IN);
    localparam int unsigned IW  = N_IN;
    localparam int unsigned MW  = N_IN + 1;

    if ((N_IN < 1) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
        $error("gate_sweep_ctrl: N_IN must be in 1..6");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_sweep_ctrl: SETTLE_CYCLES must be at least 1");
    end

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  idx;
    logic [VEC-1:0] expected_lat;
    logic [MW-1:0]  diff_count;
    logic           accept;
    logic           sample;
    logic           last;
    logic           finish;
    logic           timer_load;
    logic           timer_dec;
    logic           settle_zero;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .dec    (timer_dec),
        .zero_c (settle_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_zero) state_next = SAMPLE;
            SAMPLE:  state_next = last ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept     = 1'b0;
        sample     = 1'b0;
        finish     = 1'b0;
        timer_dec  = 1'b0;
        last       = (idx == IW'(VEC - 1));
        case (state)
            IDLE:    accept    = start;
            SETTLE:  timer_dec = 1'b1;
            SAMPLE:  sample    = 1'b1;
            DONE:    finish    = 1'b1;
            default: ;
        endcase
        timer_load = accept || (sample && !last);
    end

    // Popcount of captured-vs-expected differences; MW bits cover the all-wrong case.
    always_comb begin
        diff_count = '0;
        for (int unsigned i = 0; i < VEC; i++) begin
            diff_count = diff_count + MW'(truth_table[i] ^ expected_lat[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            gut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            truth_table    <= '0;
            expected_lat   <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                expected_lat   <= expected;
                truth_table    <= '0;
                pass           <= 1'b0;
                mismatch_count <= '0;
                idx            <= '0;
                gut_in         <= '0;
                busy           <= 1'b1;
            end
            if (sample) begin
                truth_table[idx] <= gut_out;
                if (!last) begin
                    idx    <= idx + IW'(1);
                    gut_in <= idx + IW'(1);
                end
            end
            if (finish) begin
                busy           <= 1'b0;
                gut_in         <= '0;
                pass           <= (truth_table == expected_lat);
                mismatch_count <= diff_count;
            end
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: a 2-input instance with selectable gate
// models and a 3-input instance with a longer settle time.
module tb_gate_sweep_ctrl;

    localparam int M_NAND_AND = 0;
    localparam int M_NAND     = 1;
    localparam int M_XOR      = 2;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [3:0] mc;
        int         due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         mode2 = M_NAND_AND;

    logic       start2 = 1'b0;
    logic [3:0] exp2 = '0;
    logic [1:0] gin2;
    logic       gout2;
    logic       busy2, done2, pass2;
    logic [3:0] tt2;
    logic [2:0] mc2;

    logic       start3 = 1'b0;
    logic [7:0] exp3 = '0;
    logic [2:0] gin3;
    logic       gout3;
    logic       busy3, done3, pass3;
    logic [7:0] tt3;
    logic [3:0] mc3;

    sb_t q2[$];
    sb_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(exp2), .gut_in(gin2),
        .gut_out(gout2), .busy(busy2), .done(done2), .truth_table(tt2),
        .pass(pass2), .mismatch_count(mc2)
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(exp3), .gut_in(gin3),
        .gut_out(gout3), .busy(busy3), .done(done3), .truth_table(tt3),
        .pass(pass3), .mismatch_count(mc3)
    );

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    // Gate models: a = gut_in[msb], b = gut_in[0].
    always_comb begin
        case (mode2)
            M_NAND_AND: gout2 = nand2(nand2(gin2[1], gin2[0]), nand2(gin2[1], gin2[0]));
            M_NAND:     gout2 = nand2(gin2[1], gin2[0]);
            default:    gout2 = gin2[1] ^ gin2[0];
        endcase
    end
    assign gout3 = &gin3;

    // Advance one cycle and retire any completed sweep against the scoreboard.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (done2) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL done2_unexpected: done at cycle %0d, no sweep pending", cyc);
            end else begin
                e = q2.pop_front();
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL done2_cycle: got %0d expected %0d", cyc, e.due);
                end
                n_checks++;
                if (8'(tt2) !== e.tt) begin
                    n_fail++;
                    $display("FAIL tt2: got %h expected %h", tt2, e.tt);
                end
                n_checks++;
                if (pass2 !== e.pass) begin
                    n_fail++;
                    $display("FAIL pass2: got %b expected %b", pass2, e.pass);
                end
                n_checks++;
                if (4'(mc2) !== e.mc) begin
                    n_fail++;
                    $display("FAIL mc2: got %0d expected %0d", mc2, e.mc);
                end
            end
        end
        if (done3) begin
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL done3_unexpected: done at cycle %0d, no sweep pending", cyc);
            end else begin
                e = q3.pop_front();
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL done3_cycle: got %0d expected %0d", cyc, e.due);
                end
                n_checks++;
                if (tt3 !== e.tt) begin
                    n_fail++;
                    $display("FAIL tt3: got %h expected %h", tt3, e.tt);
                end
                n_checks++;
                if (pass3 !== e.pass) begin
                    n_fail++;
                    $display("FAIL pass3: got %b expected %b", pass3, e.pass);
                end
                n_checks++;
                if (mc3 !== e.mc) begin
                    n_fail++;
                    $display("FAIL mc3: got %0d expected %0d", mc3, e.mc);
                end
            end
        end
    endtask

    // Called at a negedge: the next posedge is edge cyc+1.
    task automatic push2(input logic [3:0] tt, input logic p, input logic [2:0] mc, input int due_off);
        sb_t e;
        e.tt = 8'(tt); e.pass = p; e.mc = 4'(mc); e.due = cyc + 1 + due_off;
        q2.push_back(e);
    endtask

    task automatic launch2(input logic [3:0] e, input logic [3:0] tt, input logic p, input logic [2:0] mc);
        exp2 = e; start2 = 1'b1;
        push2(tt, p, mc, 9);
        step();
        start2 = 1'b0;
    endtask

    task automatic launch3(input logic [7:0] e, input logic [7:0] tt, input logic p, input logic [3:0] mc);
        sb_t s;
        exp3 = e; start3 = 1'b1;
        s.tt = tt; s.pass = p; s.mc = mc; s.due = cyc + 1 + 33;
        q3.push_back(s);
        step();
        start3 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q2.size() != 0 || q3.size() != 0) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (q2.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d sweeps still pending after %0d cycles", q2.size(), q3.size(), budget);
            q2.delete();
            q3.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        start2 = 1'b1;
        start3 = 1'b1;
        step();
        n_checks++;
        if ({busy2, done2, pass2} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags2: got %b expected 000", {busy2, done2, pass2});
        end
        n_checks++;
        if (gin2 !== 2'd0) begin n_fail++; $display("FAIL reset_gin2: got %h expected 0", gin2); end
        n_checks++;
        if (tt2 !== 4'd0) begin n_fail++; $display("FAIL reset_tt2: got %h expected 0", tt2); end
        n_checks++;
        if (mc2 !== 3'd0) begin n_fail++; $display("FAIL reset_mc2: got %0d expected 0", mc2); end
        n_checks++;
        if ({busy3, done3, pass3} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags3: got %b expected 000", {busy3, done3, pass3});
        end
        n_checks++;
        if ({gin3, tt3, mc3} !== 15'd0) begin
            n_fail++; $display("FAIL reset_data3: got %h expected 0", {gin3, tt3, mc3});
        end
        start2 = 1'b0;
        start3 = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_and_gate();
        logic [1:0] gseq [8];
        gseq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        mode2 = M_NAND_AND;
        exp2 = 4'b1000; start2 = 1'b1;
        push2(4'b1000, 1'b1, 3'd0, 9);
        for (int i = 0; i < 8; i++) begin
            step();
            start2 = 1'b0;
            n_checks++;
            if (gin2 !== gseq[i]) begin
                n_fail++; $display("FAIL gin_seq[%0d]: got %0d expected %0d", i, gin2, gseq[i]);
            end
            n_checks++;
            if (busy2 !== 1'b1) begin
                n_fail++; $display("FAIL busy_during[%0d]: got %b expected 1", i, busy2);
            end
        end
        drain(20);
        n_checks++;
        if ({busy2, gin2} !== 3'b000) begin
            n_fail++; $display("FAIL after_done: busy/gin got %b expected 000", {busy2, gin2});
        end
    endtask

    task automatic test_nand_mismatch();
        mode2 = M_NAND;
        launch2(4'b1000, 4'b0111, 1'b0, 3'd4);
        drain(20);
        n_checks++;
        if ({pass2, mc2} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL nand_hold: pass/mc got %b/%0d expected 0/4", pass2, mc2);
        end
    endtask

    task automatic test_ignore_restart();
        mode2 = M_NAND_AND;
        launch2(4'b1000, 4'b1000, 1'b1, 3'd0);
        repeat (2) step();
        start2 = 1'b1;
        exp2 = 4'b0000;
        step();
        start2 = 1'b0;
        drain(20);
        exp2 = 4'b1000;
        repeat (12) step();
    endtask

    task automatic test_reset_mid();
        mode2 = M_NAND;
        launch2(4'b1000, 4'b0111, 1'b0, 3'd4);
        void'(q2.pop_back());
        repeat (3) step();
        n_checks++;
        if (tt2 !== 4'b0001) begin
            n_fail++; $display("FAIL partial_tt: got %b expected 0001", tt2);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({busy2, done2, gin2, tt2, pass2, mc2} !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b gin=%0d tt=%b pass=%b mc=%0d expected all 0",
                     busy2, done2, gin2, tt2, pass2, mc2);
        end
        rst = 1'b0;
        repeat (12) step();
        mode2 = M_NAND_AND;
        launch2(4'b1000, 4'b1000, 1'b1, 3'd0);
        drain(20);
    endtask

    task automatic test_three_input();
        launch3(8'h80, 8'h80, 1'b1, 4'd0);
        drain(50);
        launch3(8'hFF, 8'h80, 1'b0, 4'd7);
        drain(50);
        launch3(8'h7F, 8'h80, 1'b0, 4'd8);
        drain(50);
        n_checks++;
        if (mc3 !== 4'd8) begin
            n_fail++; $display("FAIL mc3_max_hold: got %0d expected 8", mc3);
        end
    endtask

    task automatic test_back_to_back();
        mode2 = M_XOR;
        exp2 = 4'b0110; start2 = 1'b1;
        push2(4'b0110, 1'b1, 3'd0, 9);
        push2(4'b0110, 1'b1, 3'd0, 19);
        push2(4'b0110, 1'b1, 3'd0, 29);
        drain(40);
        start2 = 1'b0;
        repeat (14) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_and_gate();
        test_nand_mismatch();
        test_ignore_restart();
        test_reset_mid();
        test_three_input();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
